// File: rtl/npc_btb.sv
// Next-PC unit: owns the fetch PC, predicts through a direct-mapped BTB with 2-bit
// counters, resolves the real next PC from EX and redirects fetch on a mispredict.
module npc_btb #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_stall,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pred_npc,
  output logic            o_pred_hit,
  input  logic            i_ex_valid,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [2:0]      i_ex_npcop,
  input  logic            i_ex_is_branch,
  input  logic [XLEN-1:0] i_ex_imm,
  input  logic [XLEN-1:0] i_ex_aluout,
  input  logic [XLEN-1:0] i_ex_pred_npc,
  output logic            o_redirect,
  output logic [31:0]     o_mispred_cnt
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0]        r_pc;
  logic [31:0]            r_mispred_cnt;
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];
  logic                   r_jmp    [BTB_ENTRIES];

  logic [IDX-1:0]  w_rd_idx;
  logic [TAGW-1:0] w_rd_tag;
  logic            w_pred_hit;
  logic [XLEN-1:0] w_pred_npc;
  logic [XLEN-1:0] w_ex_plus4;
  logic [XLEN-1:0] w_ex_tgt;
  logic [XLEN-1:0] w_actual;
  logic            w_redirect;
  logic [IDX-1:0]  w_wr_idx;
  logic [TAGW-1:0] w_wr_tag;
  logic            w_ex_hit;
  logic            w_taken;
  logic            w_we;
  logic [XLEN-1:0] w_new_tgt;
  logic [1:0]      w_new_ctr;
  logic            w_new_jmp;

  assign w_rd_idx   = r_pc[IDX+1:2];
  assign w_rd_tag   = r_pc[XLEN-1:IDX+2];
  assign w_pred_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign w_pred_npc = (w_pred_hit && (r_jmp[w_rd_idx] || r_ctr[w_rd_idx][1]))
                      ? r_target[w_rd_idx] : r_pc + XLEN'(4);

  assign w_ex_plus4 = i_ex_pc + XLEN'(4);
  assign w_ex_tgt   = i_ex_pc + i_ex_imm;

  always_comb begin
    case (i_ex_npcop)
      OP_PLUS4:          w_actual = w_ex_plus4;
      OP_BRANCH, OP_JUMP: w_actual = w_ex_tgt;
      OP_JALR:           w_actual = i_ex_aluout & JALR_MASK;
      default:           w_actual = w_ex_plus4;
    endcase
  end

  assign w_redirect = i_ex_valid && (w_actual != i_ex_pred_npc);

  assign w_wr_idx = i_ex_pc[IDX+1:2];
  assign w_wr_tag = i_ex_pc[XLEN-1:IDX+2];
  assign w_ex_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
  assign w_taken  = (i_ex_npcop == OP_BRANCH);

  // A not-taken miss never allocates; JALR and plain PLUS4 leave the BTB alone.
  always_comb begin
    w_we      = 1'b0;
    w_new_tgt = w_ex_tgt;
    w_new_ctr = r_ctr[w_wr_idx];
    w_new_jmp = 1'b0;
    if (i_ex_valid) begin
      if (i_ex_is_branch) begin
        if (w_ex_hit) begin
          w_we      = 1'b1;
          w_new_jmp = r_jmp[w_wr_idx];
          w_new_tgt = w_taken ? w_ex_tgt : r_target[w_wr_idx];
          if (w_taken && (r_ctr[w_wr_idx] != 2'b11))
            w_new_ctr = r_ctr[w_wr_idx] + 2'd1;
          else if (!w_taken && (r_ctr[w_wr_idx] != 2'b00))
            w_new_ctr = r_ctr[w_wr_idx] - 2'd1;
        end else if (w_taken) begin
          w_we      = 1'b1;
          w_new_ctr = 2'b10;
        end
      end else if (i_ex_npcop == OP_JUMP) begin
        w_we      = 1'b1;
        w_new_ctr = 2'b11;
        w_new_jmp = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_pc          <= RESET_PC;
      r_mispred_cnt <= '0;
      r_valid       <= '0;
    end else begin
      if (w_redirect)
        r_pc <= w_actual;
      else if (!i_stall)
        r_pc <= w_pred_npc;
      if (w_redirect && (r_mispred_cnt != 32'hFFFF_FFFF))
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      if (w_we)
        r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Payload is meaningless while valid is clear, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_rstn && w_we) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= w_new_tgt;
      r_ctr[w_wr_idx]    <= w_new_ctr;
      r_jmp[w_wr_idx]    <= w_new_jmp;
    end
  end

  assign o_pc          = r_pc;
  assign o_pred_npc    = w_pred_npc;
  assign o_pred_hit    = w_pred_hit;
  assign o_redirect    = w_redirect;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_npc_btb.sv
// Scenario bench for npc_btb: post-edge pc/counter expectations go through a
// scoreboard queue; combinational prediction/redirect outputs are checked in place.
module tb_npc_btb;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  logic        i_clk = 1'b0;
  logic        i_rstn, i_stall, i_ex_valid, i_ex_is_branch;
  logic [31:0] i_ex_pc, i_ex_imm, i_ex_aluout, i_ex_pred_npc;
  logic [2:0]  i_ex_npcop;
  logic [31:0] o_pc, o_pred_npc, o_mispred_cnt;
  logic        o_pred_hit, o_redirect;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_cnt = 0;

  npc_btb #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_stall(i_stall),
    .o_pc(o_pc), .o_pred_npc(o_pred_npc), .o_pred_hit(o_pred_hit),
    .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_npcop(i_ex_npcop),
    .i_ex_is_branch(i_ex_is_branch), .i_ex_imm(i_ex_imm), .i_ex_aluout(i_ex_aluout),
    .i_ex_pred_npc(i_ex_pred_npc), .o_redirect(o_redirect), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ex_idle();
    i_ex_valid = 0; i_ex_pc = 0; i_ex_npcop = OP_PLUS4; i_ex_is_branch = 0;
    i_ex_imm = 0; i_ex_aluout = 0; i_ex_pred_npc = 0;
  endtask

  task automatic ex_drive(input logic [2:0] op, input logic br, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] pred);
    i_ex_valid = 1; i_ex_npcop = op; i_ex_is_branch = br; i_ex_pc = pc;
    i_ex_imm = imm; i_ex_aluout = alu; i_ex_pred_npc = pred;
    #1;
  endtask

  // Moves fetch to an arbitrary address with a mispredicted JALR (never touches the BTB).
  task automatic goto_pc(input logic [31:0] a);
    ex_drive(OP_JALR, 1'b0, 32'h0000_0F00, 32'h0, a, a + 32'd4);
    tick();
    ex_idle();
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    i_rstn = 0; i_stall = 0; ex_idle();
    repeat (2) tick();
    n_vec++;
    if (o_pc !== 32'h0 || o_pred_hit !== 1'b0 || o_mispred_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset: pc=%h hit=%b cnt=%0d, required pc=0 hit=0 cnt=0", o_pc, o_pred_hit, o_mispred_cnt);
    end
    i_rstn = 1;
    for (int i = 1; i <= 3; i++) sb.push_back('{"reset_seq", 32'(4 * i), 32'h0});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front(); n_vec++;
      if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
      end
    end
  endtask

  task automatic test_loop_training();
    logic [31:0] exp_pcs[5];
    logic        bad;
    ex_drive(OP_BRANCH, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h14);
    n_vec++;
    if (o_redirect !== 1'b1) begin n_err++; $display("FAIL loop_first_redirect: redirect=%b, required 1", o_redirect); end
    exp_cnt = exp_cnt + 1;
    sb.push_back('{"loop_first", 32'h08, exp_cnt});
    sb.push_back('{"loop_fetch_0c", 32'h0C, exp_cnt});
    sb.push_back('{"loop_fetch_10", 32'h10, exp_cnt});
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_idle();
      e = sb.pop_front(); n_vec++;
      if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
      end
    end
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h08) begin
      n_err++; $display("FAIL loop_predict: hit=%b npc=%h, required hit=1 npc=00000008", o_pred_hit, o_pred_npc);
    end
    // two correctly predicted taken resolutions: ctr 10 -> 11, no redirect
    exp_pcs[0] = 32'h08; exp_pcs[1] = 32'h0C;
    for (int i = 0; i < 2; i++) begin
      ex_drive(OP_BRANCH, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h08);
      bad = o_redirect;
      sb.push_back('{"loop_taken", exp_pcs[i], exp_cnt});
      tick();
      ex_idle();
      e = sb.pop_front(); n_vec++;
      if (bad !== 1'b0 || o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL %s: redirect=%b pc=%h cnt=%0d, required redirect=0 pc=%h cnt=%0d", e.name, bad, o_pc, o_mispred_cnt, e.pc, e.cnt);
      end
    end
    // first not-taken: ctr 11 -> 10, still predicted taken
    ex_drive(OP_PLUS4, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h08);
    exp_cnt = exp_cnt + 1;
    sb.push_back('{"loop_not_taken", 32'h14, exp_cnt});
    tick();
    ex_idle();
    e = sb.pop_front(); n_vec++;
    if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
    end
    goto_pc(32'h10);
    n_vec++;
    if (o_pc !== 32'h10 || o_pred_hit !== 1'b1 || o_pred_npc !== 32'h08) begin
      n_err++; $display("FAIL loop_ctr10: pc=%h hit=%b npc=%h, required pc=10 hit=1 npc=00000008", o_pc, o_pred_hit, o_pred_npc);
    end
    // second not-taken: ctr 10 -> 01, now predicted not taken
    ex_drive(OP_PLUS4, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h08);
    tick();
    ex_idle();
    exp_cnt = exp_cnt + 1;
    goto_pc(32'h10);
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h14 || o_mispred_cnt !== exp_cnt) begin
      n_err++; $display("FAIL loop_ctr01: hit=%b npc=%h cnt=%0d, required hit=1 npc=00000014 cnt=%0d", o_pred_hit, o_pred_npc, o_mispred_cnt, exp_cnt);
    end
  endtask

  task automatic test_no_bypass();
    i_stall = 1;
    ex_drive(OP_BRANCH, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0, 32'h08);
    n_vec++;
    if (o_redirect !== 1'b0 || o_pred_npc !== 32'h14) begin
      n_err++; $display("FAIL no_bypass_same_cycle: redirect=%b npc=%h, required redirect=0 npc=00000014", o_redirect, o_pred_npc);
    end
    sb.push_back('{"no_bypass_hold", 32'h10, exp_cnt});
    tick();
    ex_idle();
    e = sb.pop_front(); n_vec++;
    if (o_pc !== e.pc || o_mispred_cnt !== e.cnt || o_pred_npc !== 32'h08) begin
      n_err++;
      $display("FAIL %s: pc=%h cnt=%0d npc=%h, required pc=%h cnt=%0d npc=00000008", e.name, o_pc, o_mispred_cnt, o_pred_npc, e.pc, e.cnt);
    end
    i_stall = 0;
  endtask

  task automatic test_stall_redirect();
    i_stall = 1;
    ex_drive(OP_JUMP, 1'b0, 32'h40, 32'h100, 32'h0, 32'h44);
    n_vec++;
    if (o_redirect !== 1'b1) begin n_err++; $display("FAIL stall_redirect_flag: redirect=%b, required 1", o_redirect); end
    exp_cnt = exp_cnt + 1;
    sb.push_back('{"stall_redirect", 32'h140, exp_cnt});
    sb.push_back('{"stall_hold", 32'h140, exp_cnt});
    for (int i = 0; i < 2; i++) begin
      tick();
      ex_idle();
      e = sb.pop_front(); n_vec++;
      if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
      end
    end
    i_stall = 0;
    goto_pc(32'h40);
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h140) begin
      n_err++; $display("FAIL stall_jal_entry: hit=%b npc=%h, required hit=1 npc=00000140", o_pred_hit, o_pred_npc);
    end
  endtask

  task automatic test_jalr();
    ex_drive(OP_JALR, 1'b0, 32'h60, 32'h0, 32'h203, 32'h204);
    n_vec++;
    if (o_redirect !== 1'b1) begin n_err++; $display("FAIL jalr_flag: redirect=%b, required 1", o_redirect); end
    exp_cnt = exp_cnt + 1;
    sb.push_back('{"jalr_target", 32'h202, exp_cnt});
    tick();
    ex_idle();
    e = sb.pop_front(); n_vec++;
    if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
    end
    goto_pc(32'h60);
    n_vec++;
    if (o_pred_hit !== 1'b0 || o_pred_npc !== 32'h64) begin
      n_err++; $display("FAIL jalr_no_entry: hit=%b npc=%h, required hit=0 npc=00000064", o_pred_hit, o_pred_npc);
    end
  endtask

  task automatic test_alias_wrap();
    // 0x40, 0x80, 0x480 all map to index 0 of a 16-entry BTB; 0x48 maps to index 2
    ex_drive(OP_JUMP, 1'b0, 32'h40, 32'h40, 32'h0, 32'h80);
    tick();
    ex_drive(OP_JUMP, 1'b0, 32'h80, 32'h80, 32'h0, 32'h100);
    tick();
    ex_idle();
    goto_pc(32'h80);
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h100) begin
      n_err++; $display("FAIL alias_80_hit: hit=%b npc=%h, required hit=1 npc=00000100", o_pred_hit, o_pred_npc);
    end
    goto_pc(32'h40);
    n_vec++;
    if (o_pred_hit !== 1'b0 || o_pred_npc !== 32'h44) begin
      n_err++; $display("FAIL alias_40_evicted: hit=%b npc=%h, required hit=0 npc=00000044", o_pred_hit, o_pred_npc);
    end
    ex_drive(OP_JUMP, 1'b0, 32'h48, 32'h10, 32'h0, 32'h58);
    tick();
    ex_idle();
    goto_pc(32'h80);
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h100) begin
      n_err++; $display("FAIL alias_other_index: hit=%b npc=%h, required hit=1 npc=00000100", o_pred_hit, o_pred_npc);
    end
    ex_drive(OP_BRANCH, 1'b1, 32'h480, 32'h20, 32'h0, 32'h484);
    exp_cnt = exp_cnt + 1;
    sb.push_back('{"alias_branch_redirect", 32'h4A0, exp_cnt});
    tick();
    ex_idle();
    e = sb.pop_front(); n_vec++;
    if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
    end
    goto_pc(32'h80);
    n_vec++;
    if (o_pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_80_evicted: hit=%b, required 0", o_pred_hit); end
    goto_pc(32'h480);
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h4A0) begin
      n_err++; $display("FAIL alias_480_hit: hit=%b npc=%h, required hit=1 npc=000004a0", o_pred_hit, o_pred_npc);
    end
    goto_pc(32'h48);
    n_vec++;
    if (o_pred_hit !== 1'b1 || o_pred_npc !== 32'h58) begin
      n_err++; $display("FAIL alias_48_kept: hit=%b npc=%h, required hit=1 npc=00000058", o_pred_hit, o_pred_npc);
    end
    ex_drive(OP_PLUS4, 1'b1, 32'h30, 32'h40, 32'h0, 32'h34);
    tick();
    ex_idle();
    goto_pc(32'h30);
    n_vec++;
    if (o_pred_hit !== 1'b0 || o_pred_npc !== 32'h34) begin
      n_err++; $display("FAIL not_taken_no_alloc: hit=%b npc=%h, required hit=0 npc=00000034", o_pred_hit, o_pred_npc);
    end
    ex_drive(OP_PLUS4, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if (o_redirect !== 1'b0) begin n_err++; $display("FAIL wrap_match: redirect=%b, required 0", o_redirect); end
    ex_drive(OP_PLUS4, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4);
    exp_cnt = exp_cnt + 1;
    sb.push_back('{"wrap_redirect", 32'h0, exp_cnt});
    tick();
    ex_idle();
    e = sb.pop_front(); n_vec++;
    if (o_pc !== e.pc || o_mispred_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s: pc=%h cnt=%0d, required pc=%h cnt=%0d", e.name, o_pc, o_mispred_cnt, e.pc, e.cnt);
    end
  endtask

  task automatic test_midop_reset();
    ex_drive(OP_JUMP, 1'b0, 32'h20, 32'h100, 32'h0, 32'h24);
    i_rstn = 0;
    exp_cnt = 0;
    sb.push_back('{"midop_reset", 32'h0, 32'h0});
    tick();
    ex_idle();
    i_rstn = 1;
    e = sb.pop_front(); n_vec++;
    if (o_pc !== e.pc || o_mispred_cnt !== e.cnt || o_pred_hit !== 1'b0) begin
      n_err++;
      $display("FAIL %s: pc=%h cnt=%0d hit=%b, required pc=%h cnt=%0d hit=0", e.name, o_pc, o_mispred_cnt, o_pred_hit, e.pc, e.cnt);
    end
    goto_pc(32'h48);
    n_vec++;
    if (o_pred_hit !== 1'b0 || o_mispred_cnt !== exp_cnt) begin
      n_err++; $display("FAIL midop_48_cleared: hit=%b cnt=%0d, required hit=0 cnt=%0d", o_pred_hit, o_mispred_cnt, exp_cnt);
    end
    goto_pc(32'h20);
    n_vec++;
    if (o_pred_hit !== 1'b0) begin n_err++; $display("FAIL midop_jal_dropped: hit=%b, required 0", o_pred_hit); end
    goto_pc(32'h480);
    n_vec++;
    if (o_pred_hit !== 1'b0 || o_pred_npc !== 32'h484) begin
      n_err++; $display("FAIL midop_480_cleared: hit=%b npc=%h, required hit=0 npc=00000484", o_pred_hit, o_pred_npc);
    end
  endtask

  initial begin
    test_reset();
    test_loop_training();
    test_no_bypass();
    test_stall_redirect();
    test_jalr();
    test_alias_wrap();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
